// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, ALU operation codes and the
// RV32I major opcodes used by the issue stage and the ALU itself.
package alu_pkg;

  localparam int XLEN         = 32;
  localparam int ALU_OP_WIDTH = 4;

  // ALU operation encoding seen by the execute stage
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SEQ  = 4'd6,
    ALU_SNE  = 4'd7,
    ALU_SUB  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_SLT  = 4'd10,
    ALU_SGE  = 4'd11,
    ALU_SLTU = 4'd12,
    ALU_SGEU = 4'd13
  } alu_op_e;

  // RV32I major opcodes (instr[6:0], including the 2'b11 length bits)
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // Sign-extend a 12-bit immediate to XLEN
  function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode for the ALU issue stage: picks the ALU
// operation, the A/B operands and the destination register, and flags
// encodings the ALU path cannot execute.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]             instr,
  input  logic [XLEN-1:0]         pc,
  input  logic [XLEN-1:0]         rs1,
  input  logic [XLEN-1:0]         rs2,
  output logic [ALU_OP_WIDTH-1:0] op,
  output logic [XLEN-1:0]         a,
  output logic [XLEN-1:0]         b,
  output logic [4:0]              rd,
  output logic                    illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = sext12(instr[31:20]);
  assign imm_s  = sext12({instr[31:25], instr[11:7]});
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

  // The rs1 index field is resolved by the register file upstream
  logic unused_rs1_field;
  assign unused_rs1_field = ^instr[19:15];

  // Decode operation and operands; an illegal encoding collapses to ADD 0,0
  always_comb begin
    logic [ALU_OP_WIDTH-1:0] op_next;
    logic [XLEN-1:0]         a_next;
    logic [XLEN-1:0]         b_next;
    logic [4:0]              rd_next;
    logic                    ill_next;

    op_next  = ALU_ADD;
    a_next   = '0;
    b_next   = '0;
    rd_next  = instr[11:7];
    ill_next = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        a_next = rs1;
        b_next = rs2;
        if (funct7 == FUNCT7_BASE) begin
          unique case (funct3)
            3'b000: op_next = ALU_ADD;
            3'b001: op_next = ALU_SLL;
            3'b010: op_next = ALU_SLT;
            3'b011: op_next = ALU_SLTU;
            3'b100: op_next = ALU_XOR;
            3'b101: op_next = ALU_SRL;
            3'b110: op_next = ALU_OR;
            default: op_next = ALU_AND;
          endcase
        end else if (funct7 == FUNCT7_ALT) begin
          // only ADD and SRL have an alternate form
          if (funct3 == 3'b000)      op_next = ALU_SUB;
          else if (funct3 == 3'b101) op_next = ALU_SRA;
          else                       ill_next = 1'b1;
        end else begin
          ill_next = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        a_next = rs1;
        b_next = imm_i;
        unique case (funct3)
          3'b000: op_next = ALU_ADD;
          3'b001: begin
            b_next  = shamt;
            op_next = ALU_SLL;
            if (funct7 != FUNCT7_BASE) ill_next = 1'b1;
          end
          3'b010: op_next = ALU_SLT;
          3'b011: op_next = ALU_SLTU;
          3'b100: op_next = ALU_XOR;
          3'b101: begin
            b_next = shamt;
            if (funct7 == FUNCT7_BASE)     op_next = ALU_SRL;
            else if (funct7 == FUNCT7_ALT) op_next = ALU_SRA;
            else                           ill_next = 1'b1;
          end
          3'b110: op_next = ALU_OR;
          default: op_next = ALU_AND;
        endcase
      end

      OPC_LUI: begin
        a_next = '0;
        b_next = imm_u;
      end

      OPC_AUIPC: begin
        a_next = pc;
        b_next = imm_u;
      end

      OPC_BRANCH: begin
        a_next  = rs1;
        b_next  = rs2;
        rd_next = 5'd0;
        unique case (funct3)
          3'b000: op_next = ALU_SEQ;
          3'b001: op_next = ALU_SNE;
          3'b100: op_next = ALU_SLT;
          3'b101: op_next = ALU_SGE;
          3'b110: op_next = ALU_SLTU;
          3'b111: op_next = ALU_SGEU;
          default: ill_next = 1'b1;
        endcase
      end

      OPC_LOAD: begin
        a_next = rs1;
        b_next = imm_i;
      end

      OPC_STORE: begin
        a_next  = rs1;
        b_next  = imm_s;
        rd_next = 5'd0;
      end

      OPC_JAL: begin
        // ALU produces the link value pc+4
        a_next = pc;
        b_next = XLEN'(4);
      end

      OPC_JALR: begin
        a_next = pc;
        b_next = XLEN'(4);
        if (funct3 != 3'b000) ill_next = 1'b1;
      end

      default: ill_next = 1'b1;
    endcase

    if (ill_next) begin
      op_next = ALU_ADD;
      a_next  = '0;
      b_next  = '0;
      rd_next = 5'd0;
    end

    op      = op_next;
    a       = a_next;
    b       = b_next;
    rd      = rd_next;
    illegal = ill_next;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: one valid/ready pipeline register in front of the ALU,
// loaded from the combinational decoder. Flush kills the held entry and
// blocks acceptance in the same cycle.
module alu_issue
  import alu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_rs1,
  input  logic [XLEN-1:0]         in_rs2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ALU_OP_WIDTH-1:0] out_op,
  output logic [XLEN-1:0]         out_a,
  output logic [XLEN-1:0]         out_b,
  output logic [4:0]              out_rd,
  output logic                    out_illegal
);

  logic [ALU_OP_WIDTH-1:0] dec_op;
  logic [XLEN-1:0]         dec_a;
  logic [XLEN-1:0]         dec_b;
  logic [4:0]              dec_rd;
  logic                    dec_illegal;

  logic                    valid_reg;
  logic [ALU_OP_WIDTH-1:0] op_reg;
  logic [XLEN-1:0]         a_reg;
  logic [XLEN-1:0]         b_reg;
  logic [4:0]              rd_reg;
  logic                    illegal_reg;
  logic                    accept;

  alu_decode u_decode (
    .instr   (in_instr),
    .pc      (in_pc),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .op      (dec_op),
    .a       (dec_a),
    .b       (dec_b),
    .rd      (dec_rd),
    .illegal (dec_illegal)
  );

  // The slot is free when empty or draining this cycle; flush overrides
  assign in_ready = !flush && (!valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // Valid flag: flush wins, then accept refills, then a transfer empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg <= 1'b1;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  // Payload loads only on accept and otherwise holds its last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      rd_reg      <= '0;
      illegal_reg <= 1'b0;
    end else if (accept) begin
      op_reg      <= dec_op;
      a_reg       <= dec_a;
      b_reg       <= dec_b;
      rd_reg      <= dec_rd;
      illegal_reg <= dec_illegal;
    end
  end

  assign out_valid   = valid_reg;
  assign out_op      = op_reg;
  assign out_a       = a_reg;
  assign out_b       = b_reg;
  assign out_rd      = rd_reg;
  assign out_illegal = illegal_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed instructions push hand-computed
// results into a queue; a monitor pops and compares on every transfer.
module tb_alu_issue;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int   n_checks = 0;
  int   n_miss   = 0;
  exp_t sb[$];
  exp_t nil;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd,
                              input logic ill);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.rd = rd; e.ill = ill;
    return e;
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_op"},    {28'b0, out_op},    32'd0);
    chk({tag, "_a"},     out_a,              32'd0);
    chk({tag, "_b"},     out_b,              32'd0);
    chk({tag, "_rd"},    {27'b0, out_rd},    32'd0);
    chk({tag, "_ill"},   {31'b0, out_illegal}, 32'd0);
  endtask

  // Drive one cycle of input; if the bench expects acceptance, queue the result
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic exp_rdy, input exp_t e);
    in_valid = v; in_instr = ins; in_pc = pc; in_rs1 = r1; in_rs2 = r2;
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    if (v && exp_rdy) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer (valid && ready, no flush) must match the queue head
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_miss++;
        $display("FAIL unexpected_transfer: got op=%0d a=0x%08h, expected no entry", out_op, out_a);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("xfer op=%0d a=0x%08h b=0x%08h rd=%0d ill=%0d", out_op, out_a, out_b, out_rd, out_illegal);
        chk("xfer_op",  {28'b0, out_op},      {28'b0, e.op});
        chk("xfer_a",   out_a,                e.a);
        chk("xfer_b",   out_b,                e.b);
        chk("xfer_rd",  {27'b0, out_rd},      {27'b0, e.rd});
        chk("xfer_ill", {31'b0, out_illegal}, {31'b0, e.ill});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nil = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("rst_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("rst_rel");
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back stream with out_ready=1
    step(1, 32'h002081B3, 32'h100, 32'd5,        32'd7, 1, mk(4'd0,  32'd5,        32'd7,        5'd3, 0)); // ADD
    step(1, 32'h402081B3, 32'h104, 32'd5,        32'd7, 1, mk(4'd8,  32'd5,        32'd7,        5'd3, 0)); // SUB
    step(1, 32'h40415093, 32'h108, 32'h80000000, 32'd0, 1, mk(4'd9,  32'h80000000, 32'd4,        5'd1, 0)); // SRAI
    step(1, 32'h02011093, 32'h10C, 32'h1234,     32'd1, 1, mk(4'd0,  32'd0,        32'd0,        5'd0, 1)); // bad SLLI
    step(1, 32'h0020F463, 32'h110, 32'd1,        32'd2, 1, mk(4'd13, 32'd1,        32'd2,        5'd0, 0)); // BGEU
    step(1, 32'h123452B7, 32'h114, 32'hAAAA,     32'hB, 1, mk(4'd0,  32'd0,        32'h12345000, 5'd5, 0)); // LUI
    step(1, 32'hFFF00093, 32'h118, 32'h55,       32'd0, 1, mk(4'd0,  32'h55,       32'hFFFFFFFF, 5'd1, 0)); // ADDI -1
    step(1, 32'hFE20AE23, 32'h11C, 32'h2000,     32'd9, 1, mk(4'd0,  32'h2000,     32'hFFFFFFFC, 5'd0, 0)); // SW -4
    step(1, 32'h008000EF, 32'h1000, 32'd3,       32'd4, 1, mk(4'd0,  32'h1000,     32'd4,        5'd1, 0)); // JAL
    step(1, 32'h00001297, 32'h400, 32'd3,        32'd4, 1, mk(4'd0,  32'h400,      32'h1000,     5'd5, 0)); // AUIPC
    step(1, 32'h0020A463, 32'h404, 32'd3,        32'd4, 1, mk(4'd0,  32'd0,        32'd0,        5'd0, 1)); // branch f3=010
    step(1, 32'h00000001, 32'h408, 32'd3,        32'd4, 1, mk(4'd0,  32'd0,        32'd0,        5'd0, 1)); // not 32-bit
    step(1, 32'h0020B1B3, 32'h40C, 32'd3,        32'd9, 1, mk(4'd12, 32'd3,        32'd9,        5'd3, 0)); // SLTU
    step(0, 32'h0,        32'h0,   32'd0,        32'd0, 1, nil);
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_hold_a", out_a, 32'd3);

    // Stall: out_ready low for three cycles with a new instruction waiting
    step(1, 32'h002081B3, 32'h500, 32'd10, 32'd20, 1, mk(4'd0, 32'd10, 32'd20, 5'd3, 0));
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h0020B1B3, 32'h504, 32'd3, 32'd9, 0, nil);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_a", out_a, 32'd10);
      chk("stall_b", out_b, 32'd20);
    end
    out_ready = 1'b1;
    step(1, 32'h0020B1B3, 32'h504, 32'd3, 32'd9, 1, mk(4'd12, 32'd3, 32'd9, 5'd3, 0));
    chk("b2b_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_op", {28'b0, out_op}, 32'd12);

    // Flush with an entry held and input waiting
    out_ready = 1'b0;
    flush = 1'b1;
    step(1, 32'h402081B3, 32'h508, 32'd1, 32'd1, 0, nil);
    flush = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, nil);
    chk("flush_not_consumed", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset pulse in the middle of a stall
    step(1, 32'h402081B3, 32'h600, 32'd5, 32'd7, 1, mk(4'd8, 32'd5, 32'd7, 5'd3, 0));
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;

    // One more transaction after recovering from reset
    step(1, 32'h0020F463, 32'h700, 32'd8, 32'd8, 1, mk(4'd13, 32'd8, 32'd8, 5'd0, 0));
    step(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, nil);

    // Bounded wait for the scoreboard to empty
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule
